// File: rtl/mfp_adc_max10_arbiter_if.sv
// Requester, response and MAX10 ADC sequencer command/response signals of the ADC arbiter.
// master: the arbiter side; slave: requesters plus ADC.
interface mfp_adc_max10_arbiter_if #(
    parameter int unsigned REQ_COUNT = 2,
    parameter int unsigned CH_WIDTH  = 5
);
    logic [REQ_COUNT-1:0]          REQ_Valid;
    logic [REQ_COUNT*CH_WIDTH-1:0] REQ_Channel;
    logic [REQ_COUNT-1:0]          REQ_Ready;
    logic [REQ_COUNT-1:0]          RSP_Valid;
    logic [CH_WIDTH-1:0]           RSP_Channel;
    logic [11:0]                   RSP_Data;
    logic                          ADC_C_Valid;
    logic [4:0]                    ADC_C_Channel;
    logic                          ADC_C_SOP;
    logic                          ADC_C_EOP;
    logic                          ADC_C_Ready;
    logic                          ADC_R_Valid;
    logic [4:0]                    ADC_R_Channel;
    logic [11:0]                   ADC_R_Data;

    modport master (
        input  REQ_Valid, REQ_Channel, ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data,
        output REQ_Ready, RSP_Valid, RSP_Channel, RSP_Data,
               ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP
    );

    modport slave (
        output REQ_Valid, REQ_Channel, ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data,
        input  REQ_Ready, RSP_Valid, RSP_Channel, RSP_Data,
               ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP
    );
endinterface

// File: rtl/mfp_adc_max10_arbiter.sv
// Round-robin arbiter sharing one MAX10 ADC sequencer between REQ_COUNT requesters;
// an in-order tag FIFO routes each result back to the requester that ordered it.
module mfp_adc_max10_arbiter #(
    parameter int unsigned REQ_COUNT  = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CH_WIDTH   = 5
) (
    input  logic                        CLK,
    input  logic                        RESETn,
    mfp_adc_max10_arbiter_if.master     bus,
    output logic                        Busy,
    output logic                        Err,
    input  logic                        ErrClear
);

    localparam int unsigned IDX_W    = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned ADC_CH_W = 5;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CMD  = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0]    req;
        logic [CH_WIDTH-1:0] ch;
    } tag_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [CH_WIDTH-1:0]    chan_q, chan_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    tag_t                   fifo_q [FIFO_DEPTH];
    logic                   err_q, err_d;
    logic [REQ_COUNT-1:0]   rsp_valid_q, rsp_valid_d;
    logic [CH_WIDTH-1:0]    rsp_ch_q;
    logic [11:0]            rsp_data_q;

    logic                   push, pop, err_set, full;
    logic                   scan_hit;
    logic [IDX_W-1:0]       scan_idx;
    int unsigned            scan_pos;
    tag_t                   head;
    logic [REQ_COUNT-1:0]   req_ready_c;

    // First asserted requester at or above the RR pointer, wrapping.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        scan_pos = 0;
        for (int unsigned off = 0; off < REQ_COUNT; off++) begin
            scan_pos = 32'(rr_q) + off;
            if (scan_pos >= REQ_COUNT) begin
                scan_pos = scan_pos - REQ_COUNT;
            end
            if (!scan_hit && bus.REQ_Valid[IDX_W'(scan_pos)]) begin
                scan_hit = 1'b1;
                scan_idx = IDX_W'(scan_pos);
            end
        end
    end

    // Full check is on the registered count: a same-cycle pop does not free a slot yet.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        chan_d      = chan_q;
        push        = 1'b0;
        req_ready_c = '0;
        full        = (count_q == CNT_W'(FIFO_DEPTH));
        case (state_q)
            S_IDLE: begin
                if (scan_hit && !full) begin
                    grant_d = scan_idx;
                    chan_d  = bus.REQ_Channel[32'(scan_idx) * CH_WIDTH +: CH_WIDTH];
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.ADC_C_Ready) begin
                    push                 = 1'b1;
                    req_ready_c[grant_q] = 1'b1;
                    rr_d    = (grant_q == IDX_W'(REQ_COUNT - 1)) ? '0 : IDX_W'(grant_q + 1'b1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response routing and protocol error detection.
    always_comb begin
        head        = fifo_q[rd_ptr_q];
        pop         = bus.ADC_R_Valid && (count_q != '0);
        err_set     = bus.ADC_R_Valid &&
                      ((count_q == '0) || (ADC_CH_W'(head.ch) != bus.ADC_R_Channel));
        rsp_valid_d = '0;
        if (pop) begin
            rsp_valid_d[head.req] = 1'b1;
        end
        err_d = err_set ? 1'b1 : (ErrClear ? 1'b0 : err_q);
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            chan_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_ch_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            chan_q      <= chan_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                rsp_ch_q   <= CH_WIDTH'(bus.ADC_R_Channel);
                rsp_data_q <= bus.ADC_R_Data;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Tag storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (RESETn && push) begin
            fifo_q[wr_ptr_q] <= '{req: grant_q, ch: chan_q};
        end
    end

    assign bus.REQ_Ready     = req_ready_c;
    assign bus.RSP_Valid     = rsp_valid_q;
    assign bus.RSP_Channel   = rsp_ch_q;
    assign bus.RSP_Data      = rsp_data_q;
    assign bus.ADC_C_Valid   = (state_q == S_CMD);
    assign bus.ADC_C_SOP     = (state_q == S_CMD);
    assign bus.ADC_C_EOP     = (state_q == S_CMD);
    assign bus.ADC_C_Channel = ADC_CH_W'(chan_q);
    assign Busy              = (state_q != S_IDLE) || (count_q != '0);
    assign Err               = err_q;

endmodule

// File: doc/mfp_adc_max10_arbiter.md
Name: mfp_adc_max10_arbiter

Overview:
- Shares the single MAX10 ADC sequencer command/response interface between REQ_COUNT independent requesters, e.g. a CPU-facing register core, a periodic sampler and a DMA-like logger.
- Each requester issues single-channel conversion commands. The block grants them round-robin and drives one-sample Avalon-ST command packets to the ADC.
- Each result is routed back to the requester that ordered it, using an in-order tag FIFO of outstanding commands.

Parameters:
- REQ_COUNT, 2, number of requesters (2..4).
- FIFO_DEPTH, 4, maximum outstanding commands (power of two, 2..8).
- CH_WIDTH, 5, ADC channel field width.

Ports:
- CLK  in  1  clock.
- RESETn  in  1  reset, synchronous, active-low.
- REQ_Valid  in  REQ_COUNT  per-requester command request.
- REQ_Channel  in  REQ_COUNT*CH_WIDTH  per-requester channel, requester i at bits [i*CH_WIDTH +: CH_WIDTH].
- REQ_Ready  out  REQ_COUNT  command accepted (one-cycle pulse).
- RSP_Valid  out  REQ_COUNT  result strobe to the owning requester.
- RSP_Channel  out  CH_WIDTH  result channel, shared by all requesters.
- RSP_Data  out  12  result sample, shared by all requesters.
- ADC_C_Valid  out  1  command valid.
- ADC_C_Channel  out  5  command channel.
- ADC_C_SOP  out  1  command start of packet.
- ADC_C_EOP  out  1  command end of packet.
- ADC_C_Ready  in  1  ADC accepts command.
- ADC_R_Valid  in  1  response valid.
- ADC_R_Channel  in  5  response channel.
- ADC_R_Data  in  12  response sample.
- Busy  out  1  state != S_IDLE or FIFO not empty.
- Err  out  1  sticky protocol error.
- ErrClear  in  1  clears Err.

Behaviour:
Reset values:
- State=S_IDLE, RR pointer=0, FIFO empty (count=0), Err=0.
- All outputs 0, ADC_C_Channel=0.

State machine:
- S_IDLE: if any REQ_Valid and FIFO count < FIFO_DEPTH, grant and go to S_CMD.
  - Grant = first asserted requester scanning from the RR pointer upward, with wrap.
  - Latch the grant index and its REQ_Channel.
  - If the FIFO is full, stay in S_IDLE and grant nothing.
- S_CMD: ADC_C_Valid=ADC_C_SOP=ADC_C_EOP=1; ADC_C_Channel=latched channel, stable until accepted.
  - When ADC_C_Ready=1, the command is accepted:
    - REQ_Ready[grant]=1 in that same cycle (combinational from ADC_C_Ready).
    - Push {grant, channel} into the FIFO.
    - RR pointer <= (grant+1) mod REQ_COUNT.
    - Next state is S_IDLE.
  - Otherwise hold S_CMD.
- Command latency: REQ_Valid seen in S_IDLE -> ADC_C_Valid on the next cycle. Minimum two cycles per command.

Requester rules:
- A requester holds REQ_Valid and REQ_Channel until its REQ_Ready pulse.
- Dropping REQ_Valid after grant does not cancel the command: the latched command is still issued, and REQ_Ready still pulses.

Response path:
- On ADC_R_Valid with FIFO non-empty:
  - Pop the FIFO head.
  - Next cycle: RSP_Valid[head.req]=1 for exactly one cycle, RSP_Data/RSP_Channel = registered ADC_R_Data/ADC_R_Channel.
- If ADC_R_Channel != head.channel, still route to head.req and set Err.
- ADC_R_Valid with FIFO empty: drop the response (no RSP_Valid) and set Err.

FIFO and counters:
- Push and pop in the same cycle are allowed; count is unchanged.
- The full check uses the registered count, so no grant is made while full even if a pop occurs that cycle.
- Pointers are modulo FIFO_DEPTH.

Err:
- Set has priority over ErrClear in the same cycle.
- Otherwise ErrClear=1 clears Err on the next edge.

Reset mid-operation:
- RESETn=0 in any state returns to reset values next edge.
- Outstanding tags are discarded. Later ADC responses hit an empty FIFO and set Err; this is expected, and software clears it.

Test Plan:
- Single command: REQ_Valid[0]=1, channel=3, ADC_C_Ready=1 -> ADC_C_Valid/SOP/EOP=1, channel 3, one cycle after request. REQ_Ready[0] pulses once. ADC_R_Valid channel 3, data 0xABC -> RSP_Valid[0] one cycle later, RSP_Data=0xABC.
- Round-robin: REQ_Valid=2'b11 held, channels 1 and 2 -> commands issued in order 0,1,0,1. Responses route to RSP_Valid[0],[1],[0],[1] in the same order.
- Back-pressure: ADC_C_Ready=0 for 5 cycles in S_CMD -> ADC_C_Valid and ADC_C_Channel stable for all 5 cycles, no REQ_Ready. Accepted in the cycle Ready rises.
- FIFO full: 4 commands accepted with no responses -> 5th request not granted, Busy=1. One response -> 5th granted on a following cycle.
- Errors: ADC_R_Valid with FIFO empty -> no RSP_Valid, Err=1. ErrClear -> Err=0. Response channel 7 vs tag channel 3 -> Err=1, RSP_Valid still to the tagged requester.
- Reset mid-S_CMD with 2 tags outstanding -> next cycle ADC_C_Valid=0, Busy=0, RR pointer=0.
